// File: rtl/loop_nest_ctrl_pkg.sv
// cnn_accel_pkg: definitions shared by the loop-nest sequencer and the
// surrounding convolution datapath blocks.
//   CNN_CW        default width of an iteration index counter
//   loop_state_t  sequencer state encoding (IDLE / RUN / DONE)
package cnn_accel_pkg;

  localparam int CNN_CW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } loop_state_t;

endpackage

// File: rtl/loop_nest_ctrl_if.sv
// loop_nest_ctrl_if: handshake and iteration-stream bundle of the loop-nest
// sequencer.
//   master modport : issuer side (drives start/ena[/abort], observes stream)
//   slave modport  : sequencer side
//   start, ena        issuer -> sequencer
//   abort             issuer -> sequencer, only when LOOP_NEST_ABORT_EN is defined
//   busy, iter_vld    sequencer status / "indices consumed this cycle"
//   idx0, idx1, idx2  inner, middle, outer index (CW bits each)
//   last0, last_all   innermost-at-end / final-iteration flags
//   done              one-cycle pulse after the nest has finished
interface loop_nest_ctrl_if
  import cnn_accel_pkg::*;
#(
  parameter int CW = CNN_CW
);

  logic          start;
  logic          ena;
`ifdef LOOP_NEST_ABORT_EN
  logic          abort;
`endif
  logic          busy;
  logic          iter_vld;
  logic [CW-1:0] idx0;
  logic [CW-1:0] idx1;
  logic [CW-1:0] idx2;
  logic          last0;
  logic          last_all;
  logic          done;

`ifdef LOOP_NEST_ABORT_EN
  modport master (
    output start, ena, abort,
    input  busy, iter_vld, idx0, idx1, idx2, last0, last_all, done
  );
  modport slave (
    input  start, ena, abort,
    output busy, iter_vld, idx0, idx1, idx2, last0, last_all, done
  );
`else
  modport master (
    output start, ena,
    input  busy, iter_vld, idx0, idx1, idx2, last0, last_all, done
  );
  modport slave (
    input  start, ena,
    output busy, iter_vld, idx0, idx1, idx2, last0, last_all, done
  );
`endif

endinterface

// File: rtl/loop_nest_ctrl_loop_level.sv
// loop_level: one wrapping index counter of the loop nest.
//   clk     rising-edge clock
//   rst     synchronous active-low reset
//   clr     force index back to 0 (end of nest / abort), wins over adv
//   adv     step the index by one this cycle
//   idx     current index, 0 .. MAX-1
//   at_max  idx == MAX-1
//   wrap    adv & at_max; drives adv of the next outer level
// With MAX=1 the index never leaves 0 and every advance is also a wrap.
module loop_level #(
  parameter int CW  = 16,
  parameter int MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [CW-1:0] idx,
  output logic          at_max,
  output logic          wrap
);

  // MAX may equal 2^CW, so the terminal value is formed as a CW-bit constant.
  localparam logic [CW-1:0] LAST = CW'(MAX - 1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (adv) begin
      idx <= at_max ? '0 : idx + 1'b1;
    end
  end

  assign at_max = (idx == LAST);
  assign wrap   = adv & at_max;

endmodule

// File: rtl/loop_nest_ctrl.sv
// loop_nest_ctrl: three-level nested-loop sequencer. After a one-cycle start
// it emits every (idx2, idx1, idx0) combination in order, idx0 fastest, one
// per cycle with ena high, then pulses done.
//   clk   rising-edge clock
//   rst   synchronous active-low reset
//   bus   loop_nest_ctrl_if.slave (start, ena, [abort], busy, iter_vld,
//         idx0..idx2, last0, last_all, done)
// Parameters: CW index width; MAX0/MAX1/MAX2 trip counts (1 .. 2^CW).
// Optional feature: macro LOOP_NEST_ABORT_EN adds the abort input, which ends
// a running nest early through the normal DONE pulse.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; indices are 0
// RUN   | iterating; one iteration consumed per cycle with ena=1
// DONE  | done pulse cycle; returns to IDLE unconditionally
module loop_nest_ctrl
  import cnn_accel_pkg::*;
#(
  parameter int CW   = CNN_CW,
  parameter int MAX0 = 8,
  parameter int MAX1 = 8,
  parameter int MAX2 = 8
) (
  input  logic            clk,
  input  logic            rst,
  loop_nest_ctrl_if.slave bus
);

  loop_state_t   state;
  logic          busy_q;
  logic          done_q;

  logic          run;
  logic          abort_hit;
  logic          clr;
  logic          adv0;
  logic          wrap0;
  logic          wrap1;
  logic          wrap2;
  logic          at0;
  logic          at1;
  logic          at2;
  logic [CW-1:0] i0;
  logic [CW-1:0] i1;
  logic [CW-1:0] i2;

  assign run = (state == RUN);

`ifdef LOOP_NEST_ABORT_EN
  assign abort_hit = run & bus.abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Abort beats ena: an aborted cycle consumes no iteration.
  assign adv0 = run & bus.ena & ~abort_hit;

  // wrap2 is the consumption of the final iteration; the levels would wrap
  // to 0 by themselves, clr makes the abort path land in the same place.
  assign clr = abort_hit | wrap2;

  loop_level #(.CW(CW), .MAX(MAX0)) u_lvl0 (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .adv    (adv0),
    .idx    (i0),
    .at_max (at0),
    .wrap   (wrap0)
  );

  loop_level #(.CW(CW), .MAX(MAX1)) u_lvl1 (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .adv    (wrap0),
    .idx    (i1),
    .at_max (at1),
    .wrap   (wrap1)
  );

  loop_level #(.CW(CW), .MAX(MAX2)) u_lvl2 (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .adv    (wrap1),
    .idx    (i2),
    .at_max (at2),
    .wrap   (wrap2)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (abort_hit || wrap2) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.iter_vld = adv0;
  assign bus.idx0     = i0;
  assign bus.idx1     = i1;
  assign bus.idx2     = i2;
  // Flags only carry meaning while a nest is running.
  assign bus.last0    = busy_q & at0;
  assign bus.last_all = busy_q & at0 & at1 & at2;

endmodule

// File: tb/tb_loop_nest_ctrl.sv
module tb_loop_nest_ctrl;

  localparam int CW = 16;
`ifdef LOOP_NEST_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst   = 1'b0;
  logic start = 1'b0;
  logic ena   = 1'b0;
  logic abort = 1'b0;
  int   sel   = 0;

  // Three instances cover the three trip-count configurations; only the
  // selected one receives start/ena, the others stay idle.
  loop_nest_ctrl_if #(.CW(CW)) if0 ();
  loop_nest_ctrl_if #(.CW(CW)) if1 ();
  loop_nest_ctrl_if #(.CW(CW)) if2 ();

  assign if0.start = start & (sel == 0);
  assign if1.start = start & (sel == 1);
  assign if2.start = start & (sel == 2);
  assign if0.ena   = ena & (sel == 0);
  assign if1.ena   = ena & (sel == 1);
  assign if2.ena   = ena & (sel == 2);
`ifdef LOOP_NEST_ABORT_EN
  assign if0.abort = abort & (sel == 0);
  assign if1.abort = abort & (sel == 1);
  assign if2.abort = abort & (sel == 2);
`endif

  loop_nest_ctrl #(.CW(CW), .MAX0(2), .MAX1(3), .MAX2(4)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  loop_nest_ctrl #(.CW(CW), .MAX0(1), .MAX1(1), .MAX2(5)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  loop_nest_ctrl #(.CW(CW), .MAX0(1), .MAX1(1), .MAX2(1)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic          o_busy, o_vld, o_last0, o_last_all, o_done;
  logic [CW-1:0] o_i0, o_i1, o_i2;

  always_comb begin
    o_busy = if0.busy; o_vld = if0.iter_vld; o_last0 = if0.last0;
    o_last_all = if0.last_all; o_done = if0.done;
    o_i0 = if0.idx0; o_i1 = if0.idx1; o_i2 = if0.idx2;
    if (sel == 1) begin
      o_busy = if1.busy; o_vld = if1.iter_vld; o_last0 = if1.last0;
      o_last_all = if1.last_all; o_done = if1.done;
      o_i0 = if1.idx0; o_i1 = if1.idx1; o_i2 = if1.idx2;
    end else if (sel == 2) begin
      o_busy = if2.busy; o_vld = if2.iter_vld; o_last0 = if2.last0;
      o_last_all = if2.last_all; o_done = if2.done;
      o_i0 = if2.idx0; o_i1 = if2.idx1; o_i2 = if2.idx2;
    end
  end

  // Reference model: a count of consumed iterations n; the indices are the
  // mixed-radix digits of n.
  int m0 = 2, m1 = 3, m2 = 4;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_n = 0;

  int total_chk = 0;
  int pass_chk  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_chk++;
    if (act === exp) pass_chk++;
    else $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
  endtask

  function automatic int tot();
    return m0 * m1 * m2;
  endfunction

  task automatic model_update(input bit r, input bit s, input bit e, input bit a);
    if (!r) begin
      m_busy = 1'b0; m_done = 1'b0; m_n = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_busy) begin
      if (a && ABORT_EN) begin
        m_busy = 1'b0; m_done = 1'b1; m_n = 0;
      end else if (e) begin
        if (m_n == tot() - 1) begin
          m_busy = 1'b0; m_done = 1'b1; m_n = 0;
        end else begin
          m_n++;
        end
      end
    end else if (s) begin
      m_busy = 1'b1;
    end
  endtask

  task automatic compare_all(input bit e, input bit a);
    chk("busy", 32'(o_busy), 32'(m_busy));
    chk("done", 32'(o_done), 32'(m_done));
    chk("iter_vld", 32'(o_vld), 32'(m_busy & e & ~(a & ABORT_EN)));
    chk("idx0", 32'(o_i0), 32'(m_n % m0));
    chk("idx1", 32'(o_i1), 32'((m_n / m0) % m1));
    chk("idx2", 32'(o_i2), 32'(m_n / (m0 * m1)));
    chk("last0", 32'(o_last0), 32'(m_busy && (m_n % m0 == m0 - 1)));
    chk("last_all", 32'(o_last_all), 32'(m_busy && (m_n == tot() - 1)));
  endtask

  // One clock: drive at negedge, check iter_vld before the edge, advance the
  // model at the edge, check everything just after it.
  task automatic step(input bit r, input bit s, input bit e, input bit a, input bit mchk);
    @(negedge clk);
    rst = r; start = s; ena = e; abort = a;
    #1;
    if (mchk) chk("iter_vld_pre", 32'(o_vld), 32'(m_busy & e & ~(a & ABORT_EN)));
    @(posedge clk);
    model_update(r, s, e, a);
    #1;
    if (mchk) compare_all(e, a);
  endtask

  task automatic set_sel(input int k);
    @(negedge clk);
    sel = k;
    case (k)
      1:       begin m0 = 1; m1 = 1; m2 = 5; end
      2:       begin m0 = 1; m1 = 1; m2 = 1; end
      default: begin m0 = 2; m1 = 3; m2 = 4; end
    endcase
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Start a nest and run it unstalled; reports start-to-done distance in
  // cycles (start cycle = 1), iterations seen and the last_all occurrences.
  task automatic run_full(output int lat, output int vcnt, output int la_cnt, output int la_i2);
    int c;
    lat = -1; la_cnt = 0; la_i2 = -1;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    c = 1;
    vcnt = int'(o_vld);
    if (o_last_all) begin la_cnt++; la_i2 = int'(o_i2); end
    for (int k = 0; k < 100 && lat < 0; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      c++;
      if (o_done) begin
        lat = c;
        chk("busy_falls_with_done", 32'(o_busy), 32'd0);
      end else begin
        vcnt += int'(o_vld);
        if (o_last_all) begin la_cnt++; la_i2 = int'(o_i2); end
      end
    end
  endtask

  typedef struct {
    bit r, s, e;
    bit busy, vld, last0, done;
    int i0, i1, i2;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int lat, vcnt, la_cnt, la_i2, dcnt;

    //            r  s  e  busy vld l0 done i0 i1 i2
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0, 0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1, 0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};

    set_sel(0);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].s, tbl[i].e, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_busy", i), 32'(o_busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_vld", i), 32'(o_vld), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_last0", i), 32'(o_last0), 32'(tbl[i].last0));
      chk($sformatf("tbl%0d_done", i), 32'(o_done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_idx0", i), 32'(o_i0), 32'(tbl[i].i0));
      chk($sformatf("tbl%0d_idx1", i), 32'(o_i1), 32'(tbl[i].i1));
      chk($sformatf("tbl%0d_idx2", i), 32'(o_i2), 32'(tbl[i].i2));
    end

    // Unstalled 2x3x4 nest.
    set_sel(0);
    run_full(lat, vcnt, la_cnt, la_i2);
    chk("full_done_latency", 32'(lat), 32'd25);
    chk("full_iter_count", 32'(vcnt), 32'd24);
    chk("full_last_all_count", 32'(la_cnt), 32'd1);

    // ena pattern 1,1,0,1 with start held high through RUN and DONE.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    vcnt = int'(o_vld);
    lat = -1;
    for (int k = 0; k < 80 && lat < 0; k++) begin
      step(1'b1, 1'b1, (k % 4) != 2, 1'b0, 1'b1);
      if (o_done) lat = k; else vcnt += int'(o_vld);
    end
    chk("stall_done_seen", 32'(lat >= 0), 32'd1);
    chk("stall_iter_count", 32'(vcnt), 32'd24);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("start_in_done_ignored", 32'(o_busy), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("restart_busy", 32'(o_busy), 32'd1);
    chk("restart_idx0", 32'(o_i0), 32'd0);
    for (int k = 0; k < 40 && m_busy; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset at iteration 10.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("pre_reset_idx1", 32'(o_i1), 32'd2);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_idx0", 32'(o_i0), 32'd0);
    dcnt = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      dcnt += int'(o_done);
    end
    chk("no_done_after_reset", 32'(dcnt), 32'd0);
    run_full(lat, vcnt, la_cnt, la_i2);
    chk("post_reset_latency", 32'(lat), 32'd25);
    chk("post_reset_iter_count", 32'(vcnt), 32'd24);

    // 1x1x5 and 1x1x1.
    set_sel(1);
    run_full(lat, vcnt, la_cnt, la_i2);
    chk("m115_latency", 32'(lat), 32'd6);
    chk("m115_iter_count", 32'(vcnt), 32'd5);
    chk("m115_last_all_count", 32'(la_cnt), 32'd1);
    chk("m115_last_all_idx2", 32'(la_i2), 32'd4);
    set_sel(2);
    run_full(lat, vcnt, la_cnt, la_i2);
    chk("m111_latency", 32'(lat), 32'd2);
    chk("m111_iter_count", 32'(vcnt), 32'd1);

`ifdef LOOP_NEST_ABORT_EN
    set_sel(0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("pre_abort_idx0", 32'(o_i0), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("abort_done", 32'(o_done), 32'd1);
    chk("abort_idx1", 32'(o_i1), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("abort_done_one_cycle", 32'(o_done), 32'd0);
`endif

    // Randomized traffic on every configuration.
    for (int s = 0; s < 3; s++) begin
      set_sel(s);
      for (int k = 0; k < 700; k++) begin
        step($urandom_range(0, 199) != 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) != 0,
             ABORT_EN && ($urandom_range(0, 40) == 0),
             1'b1);
      end
    end

    $display("%0d/%0d checks passed", pass_chk, total_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/loop_nest_ctrl.md
# loop_nest_ctrl

Three-level nested-loop sequencer for the convolution datapath. Accepts a one-cycle `start`, then steps three loop indices (innermost `idx0`, middle `idx1`, outermost `idx2`) through every combination, one iteration per cycle while `ena` is high. Pulses `done` after the final iteration. It sequences the existing wrap-around counters with the same `start`/`ena`/`done` handshake style, so tile loaders and PE arrays see a single ordered iteration stream.

## Interface
Parameters:
- `CW`, 16: width of each index counter
- `MAX0`, 8: trip count of the innermost loop (idx0); 1 ≤ MAX0 ≤ 2^CW
- `MAX1`, 8: trip count of the middle loop (idx1); same range
- `MAX2`, 8: trip count of the outermost loop (idx2); same range

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-low reset; sampled on `clk`
- `start`  in  1  begin a new loop nest; honoured only in IDLE
- `ena`  in  1  advance enable; one iteration consumed per cycle with `ena`=1 in RUN
- `busy`  out  1  high in RUN
- `iter_vld`  out  1  current indices valid and consumed this cycle (RUN & `ena`)
- `idx0`  out  CW  innermost index
- `idx1`  out  CW  middle index
- `idx2`  out  CW  outermost index
- `last0`  out  1  `idx0` == MAX0-1
- `last_all`  out  1  final iteration of the whole nest
- `done`  out  1  one-cycle pulse after final iteration consumed
- `abort`  in  1  only with `LOOP_NEST_ABORT_EN`; see Configuration

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start`=1 → RUN; indices already 0. `ena` ignored.
- RUN: `iter_vld` = `ena`. Each cycle with `ena`=1:
  - `idx0` increments, wrapping to 0 at MAX0-1.
  - On `idx0` wrap, `idx1` increments, wrapping at MAX1-1.
  - On `idx1` wrap, `idx2` increments.
- RUN: `ena`=0 holds all indices and state (stall).
- RUN: `ena`=1 while `last_all`=1 (all three at MAXn-1) → DONE; indices clear to 0.
- DONE: `done`=1 for exactly one cycle → IDLE unconditionally. `start` in DONE is ignored.
- `start` in RUN or DONE is ignored, with no restart and no queueing.
- Any level with MAXn=1 stays at 0 and carries on every advance.
- Total iterations = MAX0·MAX1·MAX2, each emitted exactly once in order, idx0 fastest.
- Index arithmetic is unsigned CW-bit. Compare against MAXn-1 as CW-bit constants; no overflow past MAXn-1 is permitted.
- `last0` and `last_all` are combinational from the index registers. They are meaningful only while `busy`=1 and forced 0 otherwise.

## Timing
- Reset (`rst`=0 at a rising edge): state IDLE; `idx0`/`idx1`/`idx2`=0; `done`=0; `busy`=0; `iter_vld`=0; `last0`=0; `last_all`=0. Applies mid-operation, discarding the nest with no `done` pulse.
- `start` sampled at edge t → `busy`=1 from t+1. First iteration can be consumed in cycle t+1.
- Final iteration consumed at edge t_f → `busy`=0 and `done`=1 during cycle t_f+1 → IDLE at t_f+2.
- Earliest restart: `start` sampled at t_f+2, which gives one dead cycle (DONE) between nests.
- Unstalled nest: `start` to `done` = MAX0·MAX1·MAX2 + 1 cycles.
- `iter_vld` is combinational from state and `ena`. The indices, `busy` and `done` are registered.

## Configuration
- Macro `LOOP_NEST_ABORT_EN`.
  - Defined: `abort` input present. `abort`=1 at an edge in RUN → DONE, indices cleared, and `done` pulses as normal. `abort` in IDLE/DONE has no effect. `abort` takes priority over `ena` in the same cycle.
  - Undefined: no `abort` port. A nest can only end by completing or by reset.

## Structure
- Shared package `cnn_accel_pkg`:
  - state enum `loop_state_t` (IDLE/RUN/DONE)
  - default CW constant
- Sub-module `loop_level`: one wrapping counter with parameters `CW` and `MAX`.
  - Inputs: `clk`, `rst`, `clr`, `adv`.
  - Outputs: `idx`, `at_max`, `wrap` (= `adv` & `at_max`).
  - Instantiated three times, chained `wrap`→`adv`.
- The top level holds the FSM, the `done` register and the output gating.

## Test plan
- MAX0=2, MAX1=3, MAX2=4, `ena` held 1 after `start`:
  - 24 `iter_vld` cycles, indices in order (0,0,0)…(1,2,3)
  - `done` exactly 25 cycles after the `start` edge
  - `busy` falls with `done`
- Same config, `ena` toggling 1,1,0,1 repeated: still exactly 24 iterations, no index skipped or repeated, indices frozen during `ena`=0.
- `start` reasserted mid-RUN and during DONE: no restart, sequence unchanged. A `start` two cycles after `done` begins a fresh nest from (0,0,0).
- `rst`=0 for one cycle at iteration 10: all outputs 0 next cycle, no `done` pulse, next `start` runs the full 24.
- MAX0=1, MAX1=1, MAX2=5: `idx2` 0..4 with `idx0`=`idx1`=0, `last_all` only on `idx2`=4; MAX all 1: one iteration then `done`.
- With `LOOP_NEST_ABORT_EN`: `abort`+`ena` at iteration 7 → no iteration consumed that cycle, `done` next cycle, indices 0. Without it: port absent, design elaborates.
